// File: rtl/mfsk_pkg.sv
// Shared definitions for the M-ary FSK edge-count demodulator: mode encodings,
// decision FSM states and the bits-per-symbol helper.
package mfsk_pkg;

    localparam logic [1:0] MODE_2FSK  = 2'd0;
    localparam logic [1:0] MODE_4FSK  = 2'd1;
    localparam logic [1:0] MODE_8FSK  = 2'd2;
    localparam logic [1:0] MODE_16FSK = 2'd3;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_SEARCH = 2'd1,
        D_MAP    = 2'd2
    } dstate_e;

    function automatic logic [2:0] bits_for_mode(input logic [1:0] mode);
        case (mode)
            MODE_2FSK:  bits_for_mode = 3'd1;
            MODE_4FSK:  bits_for_mode = 3'd2;
            MODE_8FSK:  bits_for_mode = 3'd3;
            MODE_16FSK: bits_for_mode = 3'd4;
            default:    bits_for_mode = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mfsk_edge_det.sv
// Synchroniser and rising-edge strobe for the hard-limited FSK input.
// Optional MFSK_DEGLITCH_EN: an edge counts only after the level holds high 2 more cycles.
module mfsk_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic fsk_i,
    output logic edge_o
);

    logic sync_q1;
    logic sync_q2;
    logic edge_q;
    logic edge_s;

`ifdef MFSK_DEGLITCH_EN
    localparam int DEGLITCH = 2;

    logic [DEGLITCH-1:0] hist_q;
    logic [DEGLITCH+1:0] lvl_s;

    // Newest level in bit 0; a counted edge is a low followed by DEGLITCH+1 highs.
    assign lvl_s  = {hist_q, sync_q2, sync_q1};
    assign edge_s = (&lvl_s[DEGLITCH:0]) & ~lvl_s[DEGLITCH+1];

    // Level history behind the synchroniser
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= {DEGLITCH{1'b0}};
        end else begin
            hist_q <= {hist_q[DEGLITCH-2:0], sync_q2};
        end
    end
`else
    assign edge_s = sync_q1 & ~sync_q2;
`endif

    // Two-flop synchroniser and registered edge strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q1 <= fsk_i;
            sync_q2 <= sync_q1;
            edge_q  <= edge_s;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/mfsk_edge_demod.sv
// M-ary FSK demodulator: counts input rising edges per symbol window and resolves the
// tone index with a one-compare-per-cycle search. Option macro: MFSK_DEGLITCH_EN.
module mfsk_edge_demod
    import mfsk_pkg::*;
#(
    parameter int SYM_LEN  = 1000,
    parameter int E0       = 4,
    parameter int ESTEP    = 4,
    parameter int MAX_BITS = 4,
    parameter int CNT_W    = $clog2(SYM_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                fsk_in,
    output logic [MAX_BITS-1:0] data_out,
    output logic                data_valid,
    output logic                range_err,
    output logic                locked
);

    localparam int KW = MAX_BITS + 1;
    localparam int TW = CNT_W + MAX_BITS + 4;
    localparam logic [TW-1:0]       LO_THR   = TW'(E0 - ESTEP / 2);
    localparam logic [TW-1:0]       HI_BASE  = TW'(E0 + ESTEP / 2);
    localparam logic [TW-1:0]       STEP     = TW'(ESTEP);
    localparam logic [KW-1:0]       K_LAST   = KW'(2 ** MAX_BITS);
    localparam logic [CNT_W-1:0]    WIN_LAST = CNT_W'(SYM_LEN - 1);
    localparam logic [MAX_BITS:0]   ONE_W    = {{MAX_BITS{1'b0}}, 1'b1};

    logic                edge_s;
    logic [CNT_W-1:0]    win_q, win_d, edge_cnt_q, edge_cnt_d, edge_inc_s, snap_s;
    logic                snap_vld_s;
    logic [1:0]          mode_q, mode_d;
    logic                locked_q, locked_d;
    dstate_e             st_q, st_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [KW-1:0]       k_q, k_d;
    logic [MAX_BITS-1:0] raw_q, raw_d, dout_q, dout_d, map_s;
    logic                perr_q, perr_d, dval_q, dval_d, rerr_q, rerr_d;
    logic [TW-1:0]       hi_s;
    logic [2:0]          bits_s;
    logic [7:0]          shift_s;
    logic [MAX_BITS:0]   half_s, rnd_s, lim_s;

    mfsk_edge_det u_edge_det (
        .clk    (clk),
        .reset  (reset),
        .fsk_i  (fsk_in),
        .edge_o (edge_s)
    );

    // Saturating edge count including this cycle's strobe
    always_comb begin
        if (edge_s && (edge_cnt_q != {CNT_W{1'b1}})) begin
            edge_inc_s = edge_cnt_q + CNT_W'(1);
        end else begin
            edge_inc_s = edge_cnt_q;
        end
    end

    // Window counter; the snapshot goes straight into the search FSM
    always_comb begin
        win_d      = win_q;
        edge_cnt_d = edge_cnt_q;
        mode_d     = mode_q;
        locked_d   = locked_q;
        snap_s     = edge_inc_s;
        snap_vld_s = 1'b0;
        if (start) begin
            win_d      = {CNT_W{1'b0}};
            edge_cnt_d = {CNT_W{1'b0}};
            mode_d     = mode;
            locked_d   = 1'b1;
        end else if (locked_q) begin
            if (win_q == WIN_LAST) begin
                snap_vld_s = 1'b1;
                win_d      = {CNT_W{1'b0}};
                edge_cnt_d = {CNT_W{1'b0}};
            end else begin
                win_d      = win_q + CNT_W'(1);
                edge_cnt_d = edge_inc_s;
            end
        end else begin
            win_d = win_q;
        end
    end

    // Round the full-grid index to the active alphabet, clamped to its top symbol
    always_comb begin
        bits_s  = bits_for_mode(mode_q);
        shift_s = 8'(MAX_BITS) - {5'd0, bits_s};
        half_s  = (ONE_W << shift_s) >> 1;
        rnd_s   = ({1'b0, raw_q} + half_s) >> shift_s;
        lim_s   = (ONE_W << bits_s) - ONE_W;
        map_s   = (rnd_s > lim_s) ? lim_s[MAX_BITS-1:0] : rnd_s[MAX_BITS-1:0];
        hi_s    = HI_BASE + TW'(k_q) * STEP;
    end

    // Decision FSM next state
    always_comb begin
        st_d   = st_q;
        rem_d  = rem_q;
        k_d    = k_q;
        raw_d  = raw_q;
        perr_d = perr_q;
        dout_d = dout_q;
        dval_d = 1'b0;
        rerr_d = 1'b0;
        if (start) begin
            st_d   = D_IDLE;
            perr_d = 1'b0;
        end else begin
            case (st_q)
                D_IDLE: begin
                    if (snap_vld_s) begin
                        st_d   = D_SEARCH;
                        rem_d  = snap_s;
                        k_d    = {KW{1'b0}};
                        perr_d = 1'b0;
                    end else begin
                        st_d = D_IDLE;
                    end
                end
                D_SEARCH: begin
                    if (TW'(rem_q) < LO_THR) begin
                        perr_d = 1'b1;
                        raw_d  = {MAX_BITS{1'b0}};
                        st_d   = D_MAP;
                    end else if (k_q == K_LAST) begin
                        perr_d = 1'b1;
                        raw_d  = {MAX_BITS{1'b1}};
                        st_d   = D_MAP;
                    end else if (TW'(rem_q) < hi_s) begin
                        raw_d = k_q[MAX_BITS-1:0];
                        st_d  = D_MAP;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                D_MAP: begin
                    dout_d = map_s;
                    dval_d = 1'b1;
                    rerr_d = perr_q;
                    st_d   = D_IDLE;
                end
                default: st_d = D_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_q      <= {CNT_W{1'b0}};
            edge_cnt_q <= {CNT_W{1'b0}};
            mode_q     <= 2'd0;
            locked_q   <= 1'b0;
            st_q       <= D_IDLE;
            rem_q      <= {CNT_W{1'b0}};
            k_q        <= {KW{1'b0}};
            raw_q      <= {MAX_BITS{1'b0}};
            perr_q     <= 1'b0;
            dout_q     <= {MAX_BITS{1'b0}};
            dval_q     <= 1'b0;
            rerr_q     <= 1'b0;
        end else begin
            win_q      <= win_d;
            edge_cnt_q <= edge_cnt_d;
            mode_q     <= mode_d;
            locked_q   <= locked_d;
            st_q       <= st_d;
            rem_q      <= rem_d;
            k_q        <= k_d;
            raw_q      <= raw_d;
            perr_q     <= perr_d;
            dout_q     <= dout_d;
            dval_q     <= dval_d;
            rerr_q     <= rerr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dval_q;
    assign range_err  = rerr_q;
    assign locked     = locked_q;

endmodule
